pe_array_sequencer: RTL and testbench

- Controller that drives the command/ack side of the PE array for one matrix-multiply job.
- Issues CLEAR and LOAD, then num_steps MAC rounds; A shifts left and B shifts up between rounds (Cannon-style; operands are pre-skewed via the overwrite inputs).
- Sits between the host/job interface and the PE array, owning command_to_execute, shift_direction and array_ack.
- Has a per-operation watchdog and an abort input.

---
 rtl/pe_array_sequencer_pkg.sv | 53 +++++
 rtl/pe_array_sequencer_if.sv | 25 ++
 rtl/pe_array_sequencer_watchdog.sv | 29 ++
 rtl/pe_array_sequencer.sv | 154 +++++++++++++++
 tb/tb_pe_array_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_sequencer_pkg.sv
// Shared constants for the PE array command path: opcodes, shift directions,
// sequencer FSM states and the op-list phase encoding.
package pe_array_pkg;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_CLEAR   = 3'd1;
    localparam logic [2:0] CMD_LOAD    = 3'd2;
    localparam logic [2:0] CMD_MAC     = 3'd3;
    localparam logic [2:0] CMD_SHIFT_A = 3'd4;
    localparam logic [2:0] CMD_SHIFT_B = 3'd5;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    // Position in the op list; PH_END means the last op has been acknowledged.
    typedef enum logic [2:0] {
        PH_CLEAR   = 3'd0,
        PH_LOAD    = 3'd1,
        PH_MAC     = 3'd2,
        PH_SHIFT_A = 3'd3,
        PH_SHIFT_B = 3'd4,
        PH_END     = 3'd5
    } phase_t;

    function automatic logic [2:0] phase_cmd(input phase_t p);
        case (p)
            PH_CLEAR:   return CMD_CLEAR;
            PH_LOAD:    return CMD_LOAD;
            PH_MAC:     return CMD_MAC;
            PH_SHIFT_A: return CMD_SHIFT_A;
            PH_SHIFT_B: return CMD_SHIFT_B;
            default:    return CMD_NOP;
        endcase
    endfunction

    // A moves left and B moves up between MAC rounds.
    function automatic logic [1:0] phase_dir(input phase_t p);
        return (p == PH_SHIFT_A) ? DIR_LEFT : DIR_UP;
    endfunction

endpackage

// File: rtl/pe_array_sequencer_if.sv
// Command/acknowledge link between the sequencer (master) and the PE array (slave).
interface pe_array_sequencer_if;
    // The master holds command_to_execute (and shift_direction) stable until the
    // slave raises array_ready; the master then pulses array_ack for one cycle
    // with the command returned to NOP, and the slave must drop array_ready
    // before the next command is presented.
    logic       array_ready;
    logic       array_ack;
    logic [2:0] command_to_execute;
    logic [1:0] shift_direction;

    modport master (
        input  array_ready,
        output array_ack,
        output command_to_execute,
        output shift_direction
    );

    modport slave (
        output array_ready,
        input  array_ack,
        input  command_to_execute,
        input  shift_direction
    );
endinterface

// File: rtl/pe_array_sequencer_watchdog.sv
// Per-operation watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th consecutive enabled cycle occurs.
module pe_op_watchdog #(
    parameter int TMO_W = 8,
    parameter int LIMIT = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/pe_array_sequencer.sv
// Sequences one matrix-multiply job on the PE array: CLEAR, LOAD, then K MAC
// rounds with A-left / B-up shifts between rounds, each op ready/ack handshaked.
module pe_array_sequencer
    import pe_array_pkg::*;
#(
    parameter int STEP_W         = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 abort,
    input  logic [STEP_W-1:0]    num_steps,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [STEP_W-1:0]    step_idx,
    pe_array_sequencer_if.master arr,
    output state_t               state_dbg
);
    state_t              state;
    phase_t              phase;
    logic [STEP_W-1:0]   k;
    logic [STEP_W-1:0]   step;
    logic [2:0]          cmd_q;
    logic [1:0]          dir_q;
    logic                ack_q;
    logic                wd_clear;
    logic                wd_enable;
    logic                wd_expired;

    // The watchdog guards both the wait for ready and the wait for its release.
    assign wd_clear  = (state == ST_ISSUE) || (state == ST_ACK);
    assign wd_enable = ((state == ST_WAIT)  && !arr.array_ready) ||
                       ((state == ST_DRAIN) &&  arr.array_ready);

    pe_op_watchdog #(
        .TMO_W (TMO_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            phase <= PH_CLEAR;
            k     <= '0;
            step  <= '0;
            cmd_q <= CMD_NOP;
            dir_q <= DIR_UP;
            ack_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            done  <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                cmd_q <= CMD_NOP;
                dir_q <= DIR_UP;
                busy  <= 1'b0;
                error <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            k     <= num_steps;
                            step  <= '0;
                            phase <= PH_CLEAR;
                            cmd_q <= CMD_CLEAR;
                            dir_q <= DIR_UP;
                            busy  <= 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (arr.array_ready) begin
                            ack_q <= 1'b1;
                            cmd_q <= CMD_NOP;
                            dir_q <= DIR_UP;
                            state <= ST_ACK;
                        end else if (wd_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            cmd_q <= CMD_NOP;
                            dir_q <= DIR_UP;
                            state <= ST_ERROR;
                        end
                    end
                    ST_ACK: begin
                        case (phase)
                            PH_CLEAR:   phase <= PH_LOAD;
                            PH_LOAD:    phase <= (k == '0) ? PH_END : PH_MAC;
                            PH_MAC:     phase <= (step == k - STEP_W'(1)) ? PH_END : PH_SHIFT_A;
                            PH_SHIFT_A: phase <= PH_SHIFT_B;
                            PH_SHIFT_B: begin
                                phase <= PH_MAC;
                                step  <= step + STEP_W'(1);
                            end
                            default:    phase <= PH_END;
                        endcase
                        state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (!arr.array_ready) begin
                            if (phase == PH_END) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                cmd_q <= phase_cmd(phase);
                                dir_q <= phase_dir(phase);
                                state <= ST_ISSUE;
                            end
                        end else if (wd_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_ERROR;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    ST_ERROR: begin
                        state <= ST_ERROR;
                    end
                    default: begin
                        cmd_q <= CMD_NOP;
                        dir_q <= DIR_UP;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign step_idx               = step;
    assign state_dbg              = state;
    assign arr.array_ack          = ack_q;
    assign arr.command_to_execute = cmd_q;
    assign arr.shift_direction    = dir_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Randomized bench for pe_array_sequencer: a responding PE array model, an
// op-list reference built from the job rules, and directed corner cases.
module tb_pe_array_sequencer;
    import pe_array_pkg::*;

    localparam int STEP_W = 8;
    localparam int TMO    = 40;
    localparam int TMO_W  = 8;
    localparam int W      = 13;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic              busy;
    logic              done;
    logic              error;
    logic [STEP_W-1:0] step_idx;
    state_t            state_dbg;

    logic auto_ready   = 1'b0;
    logic manual_ready = 1'b0;
    logic manual_mode  = 1'b0;

    pe_array_sequencer_if sif();
    assign sif.array_ready = manual_mode ? manual_ready : auto_ready;

    pe_array_sequencer #(
        .STEP_W         (STEP_W),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (TMO_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .abort     (abort),
        .num_steps (num_steps),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .step_idx  (step_idx),
        .arr       (sif),
        .state_dbg (state_dbg)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected op stream: {command, direction, step_idx} per issued op.
    logic [W-1:0] exp_q[$];
    int ack_cnt  = 0;
    int done_cnt = 0;

    int         dmin = 1;
    int         dmax = 3;
    int         drop_dly = 0;
    logic [2:0] hang_cmd = 3'd7;

    function automatic logic [W-1:0] op_word(input logic [2:0] c, input logic [1:0] d, input int s);
        return {c, d, 8'(s)};
    endfunction

    task automatic load_expected(input int k);
        exp_q.delete();
        exp_q.push_back(op_word(CMD_CLEAR, DIR_UP, 0));
        exp_q.push_back(op_word(CMD_LOAD, DIR_UP, 0));
        for (int r = 0; r < k; r++) begin
            exp_q.push_back(op_word(CMD_MAC, DIR_UP, r));
            if (r < k - 1) begin
                exp_q.push_back(op_word(CMD_SHIFT_A, DIR_LEFT, r));
                exp_q.push_back(op_word(CMD_SHIFT_B, DIR_UP, r));
            end
        end
    endtask

    function automatic int total_ops(input int k);
        return 2 + k + 2 * ((k > 0) ? k - 1 : 0);
    endfunction

    // PE array model: raises ready a random delay after a command appears,
    // drops it drop_dly cycles after the ack.
    initial begin
        int   rcnt;
        int   dcnt;
        logic pending;
        logic dropping;
        pending  = 1'b0;
        dropping = 1'b0;
        rcnt     = 0;
        dcnt     = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                auto_ready = 1'b0;
                pending    = 1'b0;
                dropping   = 1'b0;
            end else begin
                if (sif.array_ack) begin
                    if (drop_dly == 0) auto_ready = 1'b0;
                    else begin
                        dropping = 1'b1;
                        dcnt     = drop_dly;
                    end
                end else if (dropping) begin
                    dcnt--;
                    if (dcnt <= 0) begin
                        auto_ready = 1'b0;
                        dropping   = 1'b0;
                    end
                end
                if (sif.command_to_execute == CMD_NOP) begin
                    pending = 1'b0;
                end else if (!auto_ready && !pending && sif.command_to_execute != hang_cmd) begin
                    pending = 1'b1;
                    rcnt    = $urandom_range(dmax, dmin);
                    if (rcnt == 0) auto_ready = 1'b1;
                end else if (pending && !auto_ready) begin
                    rcnt--;
                    if (rcnt <= 0) auto_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard on each newly issued command, ack and done bookkeeping.
    initial begin
        logic [2:0]   prev_cmd;
        logic         prev_ack;
        logic [W-1:0] w;
        prev_cmd = CMD_NOP;
        prev_ack = 1'b0;
        forever begin
            @(negedge CLK);
            w = {sif.command_to_execute, sif.shift_direction, step_idx};
            if (sif.command_to_execute != CMD_NOP && prev_cmd == CMD_NOP) begin
                if (exp_q.size() == 0) check("op_unexpected", 32'(w), 32'h0);
                else check("op", 32'(w), 32'(exp_q.pop_front()));
                check("busy_in_op", 32'(busy), 32'h1);
            end
            if (sif.array_ack) begin
                ack_cnt++;
                check("ack_back_to_back", 32'(prev_ack), 32'h0);
                check("ack_cmd_nop", 32'(sif.command_to_execute), 32'(CMD_NOP));
                check("ack_state", 32'(state_dbg), 32'(ST_ACK));
            end
            if (done) done_cnt++;
            prev_cmd = sif.command_to_execute;
            prev_ack = sif.array_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1);
    end

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && !done && !error; n++) @(negedge CLK);
    endtask

    task automatic wait_cmd(input logic [2:0] c, input int budget);
        for (int n = 0; n < budget && sif.command_to_execute != c; n++) @(negedge CLK);
    endtask

    task automatic end_job(input int k);
        check("job_done", 32'(done), 32'h1);
        check("busy_at_done", 32'(busy), 32'h0);
        check("error_at_done", 32'(error), 32'h0);
        check("step_final", 32'(step_idx), 32'((k > 0) ? k - 1 : 0));
        @(negedge CLK);
        check("done_once", 32'(done_cnt), 32'h1);
        check("done_pulse", 32'(done), 32'h0);
        check("ack_total", 32'(ack_cnt), 32'(total_ops(k)));
        check("ops_left", 32'(exp_q.size()), 32'h0);
        check("idle_after", 32'(state_dbg), 32'(ST_IDLE));
    endtask

    task automatic run_job(input int k, input int lo, input int hi, input int drop);
        dmin     = lo;
        dmax     = hi;
        drop_dly = drop;
        load_expected(k);
        ack_cnt   = 0;
        done_cnt  = 0;
        num_steps = 8'(k);
        start     = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'h1);
        wait_done(1500);
        end_job(k);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_step", 32'(step_idx), 32'h0);
        check("rst_ack", 32'(sif.array_ack), 32'h0);
        check("rst_cmd", 32'(sif.command_to_execute), 32'(CMD_NOP));
        check("rst_dir", 32'(sif.shift_direction), 32'(DIR_UP));
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        RST_N = 1'b1;
        @(negedge CLK);

        run_job(0, 2, 2, 1);
        run_job(3, 2, 2, 1);
        for (int i = 0; i < 8; i++) begin
            int lo;
            lo = $urandom_range(2, 0);
            run_job($urandom_range(6, 0), lo, lo + $urandom_range(2, 0), $urandom_range(2, 0));
        end

        // Watchdog expiry on the first MAC, then abort out of ERROR.
        dmin = 1; dmax = 2; drop_dly = 1;
        hang_cmd = CMD_MAC;
        load_expected(2);
        num_steps = 8'd2;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_cmd(CMD_MAC, 300);
        check("mac_issued", 32'(sif.command_to_execute), 32'(CMD_MAC));
        n = 0;
        while (n < TMO + 10 && !error) begin
            @(negedge CLK);
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO + 1));
        check("tmo_error", 32'(error), 32'h1);
        check("tmo_cmd", 32'(sif.command_to_execute), 32'(CMD_NOP));
        check("tmo_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge CLK);
        check("tmo_sticky", 32'(error), 32'h1);
        check("tmo_state", 32'(state_dbg), 32'(ST_ERROR));
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_err_clear", 32'(error), 32'h0);
        check("abort_err_idle", 32'(state_dbg), 32'(ST_IDLE));
        hang_cmd = 3'd7;
        exp_q.delete();
        @(negedge CLK);

        // Abort in the same cycle ready rises during LOAD.
        manual_mode  = 1'b1;
        manual_ready = 1'b0;
        load_expected(2);
        ack_cnt = 0;
        done_cnt = 0;
        num_steps = 8'd2;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        manual_ready = 1'b1;
        @(negedge CLK);
        manual_ready = 1'b0;
        wait_cmd(CMD_LOAD, 50);
        check("load_issued", 32'(sif.command_to_execute), 32'(CMD_LOAD));
        @(negedge CLK);
        manual_ready = 1'b1;
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        manual_ready = 1'b0;
        check("abort_ack", 32'(sif.array_ack), 32'h0);
        check("abort_cmd", 32'(sif.command_to_execute), 32'(CMD_NOP));
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge CLK);
        check("abort_acks", 32'(ack_cnt), 32'h1);
        check("abort_no_done", 32'(done_cnt), 32'h0);
        manual_mode = 1'b0;
        exp_q.delete();
        run_job(1, 1, 2, 1);

        // Asynchronous reset in the WAIT of SHIFT_B.
        dmin = 2; dmax = 3; drop_dly = 1;
        load_expected(3);
        num_steps = 8'd3;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_cmd(CMD_SHIFT_B, 300);
        check("shb_issued", 32'(sif.command_to_execute), 32'(CMD_SHIFT_B));
        @(negedge CLK);
        check("shb_wait", 32'(state_dbg), 32'(ST_WAIT));
        #2 RST_N = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_cmd", 32'(sif.command_to_execute), 32'(CMD_NOP));
        check("arst_dir", 32'(sif.shift_direction), 32'(DIR_UP));
        check("arst_step", 32'(step_idx), 32'h0);
        check("arst_ack", 32'(sif.array_ack), 32'h0);
        check("arst_flags", 32'({done, error}), 32'h0);
        check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge CLK);
        #2 RST_N = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        run_job(1, 1, 3, 0);

        // start held through a K=1 job while num_steps changes to 5.
        dmin = 1; dmax = 2; drop_dly = 1;
        load_expected(1);
        ack_cnt = 0;
        done_cnt = 0;
        num_steps = 8'd1;
        start = 1'b1;
        @(negedge CLK);
        check("held_busy", 32'(busy), 32'h1);
        wait_cmd(CMD_LOAD, 50);
        num_steps = 8'd5;
        wait_done(400);
        check("held_done1", 32'(done), 32'h1);
        check("held_step1", 32'(step_idx), 32'h0);
        check("held_ops1", 32'(exp_q.size()), 32'h0);
        load_expected(5);
        @(negedge CLK);
        check("held_idle_gap", 32'(state_dbg), 32'(ST_IDLE));
        check("held_acks1", 32'(ack_cnt), 32'(total_ops(1)));
        check("held_done_cnt1", 32'(done_cnt), 32'h1);
        ack_cnt = 0;
        done_cnt = 0;
        @(negedge CLK);
        start = 1'b0;
        check("held_busy2", 32'(busy), 32'h1);
        wait_done(1500);
        end_job(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
